// File: rtl/c8_count_stage.sv
// rtl/c8_count_stage.sv - c8 counter register with 2-entry output queue (optional C8_SAT_EN: saturating count)
module c8_count_stage #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_data_a,
  input  logic [W-1:0] in_data_b,
  output logic [W-1:0] cnt_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_count,
  output logic         out_tc,
  output logic         ovf_sticky,
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [1:0]   FULL = 2'(DEPTH);
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic [W-1:0] cnt_d;
  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] head_cnt_q, head_cnt_d, tail_cnt_q, tail_cnt_d;
  logic         head_tc_q, head_tc_d, tail_tc_q, tail_tc_d;
  logic         ovf_q, ovf_d;
  state_t       state_q, state_d;

  logic         accept, pop, is_load;
  logic [W-1:0] res_cnt;
  logic         res_tc;

  assign in_ready   = (occ_q != FULL);
  assign out_valid  = (occ_q != 2'd0);
  assign out_count  = head_cnt_q;
  assign out_tc     = head_tc_q;
  assign ovf_sticky = ovf_q;
  assign fsm_state  = state_q;

  // Command decode: the c8 operation result and its terminal-count flag
  always_comb begin
    res_cnt = cnt_q;
    res_tc  = 1'b0;
    is_load = 1'b0;
    case (in_op)
      2'b01: begin res_cnt = in_data_a; is_load = 1'b1; end
      2'b10: begin res_cnt = in_data_b; is_load = 1'b1; end
      2'b11: begin
        if (cnt_q == ONES) begin
          res_tc = 1'b1;
`ifdef C8_SAT_EN
          res_cnt = ONES;
`else
          res_cnt = '0;
`endif
        end else begin
          res_cnt = cnt_q + W'(1);
        end
      end
      default: ;
    endcase
  end

  // Counter, sticky overflow and queue next-state; the head register keeps its
  // last value once the queue drains
  always_comb begin
    accept     = in_valid && in_ready;
    pop        = out_valid && out_ready;
    cnt_d      = accept ? res_cnt : cnt_q;
    ovf_d      = ovf_q;
    occ_d      = occ_q;
    head_cnt_d = head_cnt_q;
    head_tc_d  = head_tc_q;
    tail_cnt_d = tail_cnt_q;
    tail_tc_d  = tail_tc_q;
    if (accept) begin
      if (is_load) ovf_d = 1'b0;
      else if (res_tc) ovf_d = 1'b1;
    end
    case ({accept, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          head_cnt_d = res_cnt;
          head_tc_d  = res_tc;
        end else begin
          tail_cnt_d = res_cnt;
          tail_tc_d  = res_tc;
        end
      end
      2'b01: begin
        occ_d = occ_q - 2'd1;
        if (occ_q == FULL) begin
          head_cnt_d = tail_cnt_q;
          head_tc_d  = tail_tc_q;
        end
      end
      2'b11: begin
        // only reachable with one entry: the new result replaces the popped head
        head_cnt_d = res_cnt;
        head_tc_d  = res_tc;
      end
      default: ;
    endcase
  end

  // Debug FSM next-state: tracks idle / streaming / back-pressured
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (occ_d == FULL) ? STALL : RUN;
      RUN: begin
        if (occ_d == FULL) state_d = STALL;
        else if (occ_d == 2'd0 && !accept) state_d = IDLE;
      end
      STALL:   if (pop) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      occ_q      <= 2'd0;
      head_cnt_q <= '0;
      head_tc_q  <= 1'b0;
      tail_cnt_q <= '0;
      tail_tc_q  <= 1'b0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
    end else begin
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      head_cnt_q <= head_cnt_d;
      head_tc_q  <= head_tc_d;
      tail_cnt_q <= tail_cnt_d;
      tail_tc_q  <= tail_tc_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_c8_count_stage.sv
// tb/tb_c8_count_stage.sv - directed-vector bench for c8_count_stage (wrap or C8_SAT_EN build)
module tb_c8_count_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_data_a;
  logic [7:0] in_data_b;
  logic [7:0] cnt_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_count;
  logic       out_tc;
  logic       ovf_sticky;
  logic [1:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  c8_count_stage #(.W(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data_a(in_data_a), .in_data_b(in_data_b), .cnt_q(cnt_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_tc(out_tc),
    .ovf_sticky(ovf_sticky), .fsm_state(fsm_state)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid  = v;
    in_op     = op;
    in_data_a = a;
    in_data_b = b;
  endtask

  logic [1:0] seq_op  [4] = '{2'b01, 2'b11, 2'b11, 2'b11};
  logic [7:0] seq_cnt [4];
  logic       seq_tc  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] last_cnt;

  initial begin
`ifdef C8_SAT_EN
    last_cnt = 8'hFF;
`else
    last_cnt = 8'h00;
`endif
    seq_cnt = '{8'hFD, 8'hFE, 8'hFF, last_cnt};

    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("rst_out_valid", out_valid, 0);
    check_vec("rst_in_ready", in_ready, 1);
    check_vec("rst_cnt", cnt_q, 8'h00);
    check_vec("rst_ovf", ovf_sticky, 0);
    check_vec("rst_out_count", out_count, 8'h00);
    check_vec("rst_fsm", fsm_state, 0);

    // load A then three counts across the top, streaming with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq_op[i], 8'hFD, 8'h00);
      @(negedge clk);
      check_vec($sformatf("seq%0d_valid", i), out_valid, 1);
      check_vec($sformatf("seq%0d_count", i), out_count, seq_cnt[i]);
      check_vec($sformatf("seq%0d_tc", i), out_tc, seq_tc[i]);
    end
    check_vec("seq_ovf", ovf_sticky, 1);
    check_vec("seq_fsm_run", fsm_state, 1);
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check_vec("seq_drained", out_valid, 0);
    check_vec("seq_cnt_final", cnt_q, last_cnt);
    check_vec("seq_fsm_idle", fsm_state, 0);

    // hold keeps sticky; load B clears it
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check_vec("hold_ovf", ovf_sticky, 1);
    check_vec("hold_count", out_count, last_cnt);
    check_vec("hold_tc", out_tc, 0);
    drive(1'b1, 2'b10, 8'h00, 8'h05);
    @(negedge clk);
    check_vec("loadb_ovf", ovf_sticky, 0);
    check_vec("loadb_cnt", cnt_q, 8'h05);
    check_vec("loadb_count", out_count, 8'h05);
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check_vec("loadb_drained", out_valid, 0);

    // back-pressure: fill the queue, hold a third command, then release
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 8'h00, 8'h11);
    @(negedge clk);
    check_vec("bp1_in_ready", in_ready, 1);
    drive(1'b1, 2'b10, 8'h00, 8'h22);
    @(negedge clk);
    check_vec("bp2_in_ready", in_ready, 0);
    check_vec("bp2_head", out_count, 8'h11);
    check_vec("bp2_fsm_stall", fsm_state, 2);
    drive(1'b1, 2'b10, 8'h00, 8'h33);
    @(negedge clk);
    check_vec("bp3_in_ready", in_ready, 0);
    check_vec("bp3_head_stable", out_count, 8'h11);
    check_vec("bp3_cnt", cnt_q, 8'h22);
    out_ready = 1'b1;
    @(negedge clk);
    check_vec("pop1_in_ready", in_ready, 1);
    check_vec("pop1_head", out_count, 8'h22);
    check_vec("pop1_cnt_no_accept", cnt_q, 8'h22);
    check_vec("pop1_fsm_run", fsm_state, 1);
    @(negedge clk);
    check_vec("pop2_head", out_count, 8'h33);
    check_vec("pop2_cnt", cnt_q, 8'h33);
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check_vec("pop3_empty", out_valid, 0);
    check_vec("pop3_head_held", out_count, 8'h33);

    // reset with two entries queued and cnt_q=0x80, command in flight
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 8'h80, 8'h00);
    @(negedge clk);
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check_vec("pre_rst_cnt", cnt_q, 8'h80);
    check_vec("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    check_vec("rst2_out_valid", out_valid, 0);
    check_vec("rst2_cnt", cnt_q, 8'h00);
    check_vec("rst2_out_count", out_count, 8'h00);
    check_vec("rst2_in_ready", in_ready, 1);
    check_vec("rst2_fsm", fsm_state, 0);
    @(negedge clk);
    check_vec("rst2_no_stale", out_valid, 0);
    check_vec("rst2_out_tc", out_tc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
